// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and counter helper shared by the timing generator and top.
// Pure declarations: no latency, no backpressure.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t wrap_inc(input cnt_t cnt, input cnt_t last);
        return (cnt == last) ? '0 : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v pixel counters with combinational sync/active decode.
// Decode has zero latency from the counter registers; no backpressure, runs every clock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             active_o,
    output logic             h_sync_n_o,
    output logic             v_sync_n_o
);

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // The line counter advances on the same edge the pixel counter wraps.
    always_comb begin
        h_cnt_d = wrap_inc(h_cnt_q, H_LAST);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = wrap_inc(v_cnt_q, V_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o    = h_cnt_q;
    assign v_cnt_o    = v_cnt_q;
    assign active_o   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign h_sync_n_o = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign v_sync_n_o = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

endmodule

// File: rtl/vga_display_controller.sv
// VGA DAC driver: timing, visible-pixel coordinates and RGB gating; outputs idle while iRST is high.
// Colour is a zero-latency pass-through; no backpressure, the pixel source must keep pace.
module vga_display_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [9:0]       iRed,
    input  logic [9:0]       iGreen,
    input  logic [9:0]       iBlue,
    output logic [CNT_W-1:0] oCurrent_X,
    output logic [CNT_W-1:0] oCurrent_Y,
    output logic [9:0]       oVGA_R,
    output logic [9:0]       oVGA_G,
    output logic [9:0]       oVGA_B,
    output logic             oVGA_H_SYNC,
    output logic             oVGA_V_SYNC,
    output logic             oVGA_SYNC,
    output logic             oVGA_BLANK,
    output logic             oVGA_CLOCK
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             h_sync_n;
    logic             v_sync_n;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .h_cnt_o    (h_cnt),
        .v_cnt_o    (v_cnt),
        .active_o   (active),
        .h_sync_n_o (h_sync_n),
        .v_sync_n_o (v_sync_n)
    );

    always_comb begin
        oCurrent_X  = '0;
        oCurrent_Y  = '0;
        oVGA_R      = '0;
        oVGA_G      = '0;
        oVGA_B      = '0;
        oVGA_H_SYNC = 1'b1;
        oVGA_V_SYNC = 1'b1;
        oVGA_BLANK  = 1'b0;
        if (!iRST) begin
            oVGA_H_SYNC = h_sync_n;
            oVGA_V_SYNC = v_sync_n;
            oVGA_BLANK  = active;
            if (active) begin
                oCurrent_X = h_cnt;
                oCurrent_Y = v_cnt;
                oVGA_R     = iRed;
                oVGA_G     = iGreen;
                oVGA_B     = iBlue;
            end
        end
    end

    // No sync-on-green; the DAC samples on the falling pixel-clock edge.
    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_display_controller.sv
// Directed bench: full-size controller for line timing, reduced-size instance for frame timing.
module tb_vga_display_controller;

    logic       iCLK = 1'b0;
    logic       rst, rst_s;
    logic [9:0] red, green, blue;

    logic [9:0] x, y, r, g, b;
    logic       hs, vs, sync, blank, vclk;
    logic [9:0] x_s, y_s, r_s, g_s, b_s;
    logic       hs_s, vs_s, sync_s, blank_s, vclk_s;

    int passes = 0;
    int total  = 0;

    always #20 iCLK = ~iCLK;

    vga_display_controller dut (
        .iCLK(iCLK), .iRST(rst), .iRed(red), .iGreen(green), .iBlue(blue),
        .oCurrent_X(x), .oCurrent_Y(y), .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
        .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_SYNC(sync),
        .oVGA_BLANK(blank), .oVGA_CLOCK(vclk)
    );

    // 25 clocks/line (hsync 18..21), 13 lines/frame (vsync lines 8..9), 325 clocks/frame
    vga_display_controller #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .iCLK(iCLK), .iRST(rst_s), .iRed(red), .iGreen(green), .iBlue(blue),
        .oCurrent_X(x_s), .oCurrent_Y(y_s), .oVGA_R(r_s), .oVGA_G(g_s), .oVGA_B(b_s),
        .oVGA_H_SYNC(hs_s), .oVGA_V_SYNC(vs_s), .oVGA_SYNC(sync_s),
        .oVGA_BLANK(blank_s), .oVGA_CLOCK(vclk_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag, input logic [9:0] ix, input logic [9:0] iy,
                            input logic [9:0] ir, input logic [9:0] ig, input logic [9:0] ib,
                            input logic ihs, input logic ivs, input logic iblank, input logic isync);
        chk({tag, "_x"}, ix, 0);
        chk({tag, "_y"}, iy, 0);
        chk({tag, "_rgb"}, {ir, ig, ib}, 0);
        chk({tag, "_hsync"}, ihs, 1);
        chk({tag, "_vsync"}, ivs, 1);
        chk({tag, "_blank"}, iblank, 0);
        chk({tag, "_sync"}, isync, 0);
    endtask

    initial begin
        int  h, v, hh, ll;
        bit  vis, vis_s, exp_hs, exp_hs_s, exp_vs_s;
        logic [9:0] er;
        int  err_d, err_s, blank_hi, hs_lo, hs_first, hs_fall2, hs_last;
        int  s_blank_hi, s_vs_lo, s_vs_fall1, s_vs_fall2;
        int  p2_hs_first, p2_hs_first_s;
        logic prev_hs, prev_vs_s, prev_hs_s2;

        err_d = 0; err_s = 0; blank_hi = 0; hs_lo = 0;
        hs_first = -1; hs_fall2 = -1; hs_last = -1;
        s_blank_hi = 0; s_vs_lo = 0; s_vs_fall1 = -1; s_vs_fall2 = -1;
        p2_hs_first = -1; p2_hs_first_s = -1;
        prev_hs = 1'b1; prev_vs_s = 1'b1; prev_hs_s2 = 1'b1;

        rst = 1'b1; rst_s = 1'b1;
        red = 10'h3FF; green = 10'h2AA; blue = 10'h3FF;

        // Reset: counters are 0 here, so blank low proves the outputs are forced idle
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk_idle("rst", x, y, r, g, b, hs, vs, blank, sync);
        chk_idle("rst_s", x_s, y_s, r_s, g_s, b_s, hs_s, vs_s, blank_s, sync_s);
        chk("rst_dacclk_low_phase", vclk, 1);

        @(posedge iCLK);
        #1;
        chk("rst_dacclk_high_phase", vclk, 0);
        rst = 1'b0; rst_s = 1'b0;

        for (int c = 0; c < 1700; c++) begin
            @(negedge iCLK);
            // full-size reference: lines 0..2, all inside the visible rows
            h = c % 800; v = c / 800;
            vis = (h < 640);
            exp_hs = !((h >= 656) && (h <= 751));
            er = (c == 0) ? 10'h3FF : 10'h155;
            if (blank !== vis || hs !== exp_hs || vs !== 1'b1 || sync !== 1'b0 ||
                x !== (vis ? h : 0) || y !== (vis ? v : 0) ||
                r !== (vis ? er : 10'h0) || g !== (vis ? 10'h2AA : 10'h0) ||
                b !== (vis ? 10'h3FF : 10'h0))
                err_d++;
            if (c < 800 && blank === 1'b1) blank_hi++;
            if (c < 800 && hs === 1'b0) begin
                hs_lo++;
                hs_last = c;
            end
            if (prev_hs === 1'b1 && hs === 1'b0) begin
                if (hs_first < 0) hs_first = c;
                else if (hs_fall2 < 0) hs_fall2 = c;
            end
            prev_hs = hs;

            // reduced-size reference
            hh = c % 25; ll = (c / 25) % 13;
            vis_s = (hh < 16) && (ll < 6);
            exp_hs_s = !((hh >= 18) && (hh <= 21));
            exp_vs_s = !((ll == 8) || (ll == 9));
            if (blank_s !== vis_s || hs_s !== exp_hs_s || vs_s !== exp_vs_s ||
                x_s !== (vis_s ? hh : 0) || y_s !== (vis_s ? ll : 0) ||
                r_s !== (vis_s ? er : 10'h0) || b_s !== (vis_s ? 10'h3FF : 10'h0))
                err_s++;
            if (c < 650 && blank_s === 1'b1) s_blank_hi++;
            if (c < 650 && vs_s === 1'b0) s_vs_lo++;
            if (prev_vs_s === 1'b1 && vs_s === 1'b0) begin
                if (s_vs_fall1 < 0) s_vs_fall1 = c;
                else if (s_vs_fall2 < 0) s_vs_fall2 = c;
            end
            prev_vs_s = vs_s;

            if (c == 0) begin
                chk("first_x", x, 0);
                chk("first_y", y, 0);
                chk("first_blank", blank, 1);
                chk("first_red", r, 10'h3FF);
                red = 10'h155;
            end
            if (c == 639)  chk("x_last_col", x, 639);
            if (c == 1439) chk("y_line1_last_col", {y, x}, {10'd1, 10'd639});
            if (c == 1440) chk("xy_after_last_col", {blank, y, x}, 0);
            if (c == 1600) chk("line2_start", {blank, y, x}, {1'b1, 10'd2, 10'd0});
            if (c == 28)   chk("s_x3_y1", {y_s, x_s}, {10'd1, 10'd3});
            if (c == 140)  chk("s_last_pixel", {blank_s, y_s, x_s}, {1'b1, 10'd5, 10'd15});
            if (c == 141)  chk("s_after_last_pixel", {blank_s, y_s, x_s}, 0);
            if (c == 324)  chk("s_frame_end_blank", {blank_s, vs_s}, {1'b0, 1'b1});
            if (c == 325)  chk("s_frame_wrap", {blank_s, y_s, x_s}, {1'b1, 10'd0, 10'd0});
            if (c == 326)  chk("s_frame_wrap_x1", x_s, 1);
        end

        chk("line_model_errors", err_d, 0);
        chk("line_blank_clocks", blank_hi, 640);
        chk("line_hsync_low_clocks", hs_lo, 96);
        chk("line_hsync_first", hs_first, 656);
        chk("line_hsync_last", hs_last, 751);
        chk("line_period", hs_fall2 - hs_first, 800);
        chk("s_model_errors", err_s, 0);
        chk("s_blank_clocks_2frames", s_blank_hi, 192);
        chk("s_vsync_low_clocks_2frames", s_vs_lo, 100);
        chk("s_vsync_first_fall", s_vs_fall1, 200);
        chk("s_frame_period", s_vs_fall2 - s_vs_fall1, 325);

        // Mid-frame reset: full-size at line 2 col 100, reduced at line 3 col 0 (both visible)
        @(posedge iCLK);
        #1;
        rst = 1'b1; rst_s = 1'b1;
        @(negedge iCLK);
        chk_idle("midrst", x, y, r, g, b, hs, vs, blank, sync);
        chk_idle("midrst_s", x_s, y_s, r_s, g_s, b_s, hs_s, vs_s, blank_s, sync_s);
        @(posedge iCLK);
        #1;
        rst = 1'b0; rst_s = 1'b0;

        for (int c = 0; c < 800; c++) begin
            @(negedge iCLK);
            if (c == 0) begin
                chk("midrst_restart", {blank, y, x}, {1'b1, 10'd0, 10'd0});
                chk("midrst_restart_red", r, 10'h155);
                chk("midrst_restart_s", {blank_s, y_s, x_s}, {1'b1, 10'd0, 10'd0});
            end
            if (p2_hs_first < 0 && prev_hs === 1'b1 && hs === 1'b0) p2_hs_first = c;
            if (p2_hs_first_s < 0 && prev_hs_s2 === 1'b1 && hs_s === 1'b0) p2_hs_first_s = c;
            prev_hs = hs;
            prev_hs_s2 = hs_s;
        end
        chk("midrst_hsync_fall", p2_hs_first, 656);
        chk("midrst_hsync_fall_s", p2_hs_first_s, 18);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
